// File: rtl/execute_cycle_param_if.sv
// rtl/execute_cycle_param_if.sv - ID/EX inputs, forwarding sources and EX/MEM outputs of the execute stage.
interface execute_cycle_param_if #(parameter int XLEN = 32);
    logic            RegWriteE, MemWriteE, JumpE, JalrE, BranchE, ALUSrcE;
    logic [2:0]      BranchTypeE;
    logic [1:0]      ResultSrcE;
    logic [3:0]      ALUControlE;
    logic            MdE;
    logic [2:0]      MdOpE;
    logic [4:0]      RdE;
    logic [XLEN-1:0] RD1_E, RD2_E, ImmExtE, PCE, PCPlus4E;
    logic [1:0]      ForwardAE, ForwardBE;
    logic [XLEN-1:0] ResultW, ALUResultM;
    logic            RegWriteM, MemWriteM, MemReadM;
    logic [1:0]      ResultSrcM;
    logic [4:0]      RdM;
    logic [XLEN-1:0] ALUResultM_out, WriteDataM, PCPlus4M;
    logic            PCSrcE;
    logic [XLEN-1:0] PCTargetE;
    logic            StallE;

    modport master (
        output RegWriteE, MemWriteE, JumpE, JalrE, BranchE, ALUSrcE, BranchTypeE,
               ResultSrcE, ALUControlE, MdE, MdOpE, RdE, RD1_E, RD2_E, ImmExtE,
               PCE, PCPlus4E, ForwardAE, ForwardBE, ResultW, ALUResultM,
        input  RegWriteM, MemWriteM, MemReadM, ResultSrcM, RdM, ALUResultM_out,
               WriteDataM, PCPlus4M, PCSrcE, PCTargetE, StallE
    );

    modport slave (
        input  RegWriteE, MemWriteE, JumpE, JalrE, BranchE, ALUSrcE, BranchTypeE,
               ResultSrcE, ALUControlE, MdE, MdOpE, RdE, RD1_E, RD2_E, ImmExtE,
               PCE, PCPlus4E, ForwardAE, ForwardBE, ResultW, ALUResultM,
        output RegWriteM, MemWriteM, MemReadM, ResultSrcM, RdM, ALUResultM_out,
               WriteDataM, PCPlus4M, PCSrcE, PCTargetE, StallE
    );
endinterface

// File: rtl/execute_cycle_param.sv
// rtl/execute_cycle_param.sv - RISC-V execute stage: forwarding, ALU, branch resolve, EX/MEM register.
// Define EXEC_MDU_EN to add the iterative multiply/divide unit and its stall.
module execute_cycle_param #(
    parameter int XLEN = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    execute_cycle_param_if.slave bus
);
    localparam int SHW = $clog2(XLEN);

    logic [XLEN-1:0] fwd_a, fwd_b, src_b, alu_res, jalr_sum, ex_res;
    logic            br_take, stall;

    always_comb begin
        fwd_a = bus.RD1_E;
        fwd_b = bus.RD2_E;
        case (bus.ForwardAE)
            2'b01:   fwd_a = bus.ResultW;
            2'b10:   fwd_a = bus.ALUResultM;
            default: fwd_a = bus.RD1_E;
        endcase
        case (bus.ForwardBE)
            2'b01:   fwd_b = bus.ResultW;
            2'b10:   fwd_b = bus.ALUResultM;
            default: fwd_b = bus.RD2_E;
        endcase
        src_b = bus.ALUSrcE ? bus.ImmExtE : fwd_b;
    end

    always_comb begin
        alu_res = '0;
        case (bus.ALUControlE)
            4'b0000: alu_res = fwd_a + src_b;
            4'b0001: alu_res = fwd_a - src_b;
            4'b0010: alu_res = fwd_a & src_b;
            4'b0011: alu_res = fwd_a | src_b;
            4'b0100: alu_res = fwd_a ^ src_b;
            4'b0101: alu_res = {{(XLEN-1){1'b0}}, $signed(fwd_a) < $signed(src_b)};
            4'b0110: alu_res = {{(XLEN-1){1'b0}}, fwd_a < src_b};
            4'b0111: alu_res = fwd_a << src_b[SHW-1:0];
            4'b1000: alu_res = fwd_a >> src_b[SHW-1:0];
            4'b1001: alu_res = $signed(fwd_a) >>> src_b[SHW-1:0];
            default: alu_res = '0;
        endcase
    end

    // Branches compare against forwarded RD2, never the immediate.
    always_comb begin
        br_take = 1'b0;
        case (bus.BranchTypeE)
            3'b000:  br_take = (fwd_a == fwd_b);
            3'b001:  br_take = (fwd_a != fwd_b);
            3'b100:  br_take = ($signed(fwd_a) < $signed(fwd_b));
            3'b101:  br_take = ($signed(fwd_a) >= $signed(fwd_b));
            3'b110:  br_take = (fwd_a < fwd_b);
            3'b111:  br_take = (fwd_a >= fwd_b);
            default: br_take = 1'b0;
        endcase
    end

    assign jalr_sum      = fwd_a + bus.ImmExtE;
    assign bus.PCTargetE = bus.JalrE ? (jalr_sum & {{(XLEN-1){1'b1}}, 1'b0})
                                     : (bus.PCE + bus.ImmExtE);
    assign bus.PCSrcE    = (bus.JumpE | bus.JalrE | (bus.BranchE & br_take)) & ~stall;
    assign bus.StallE    = stall;

`ifdef EXEC_MDU_EN
    typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_DONE} md_state_t;

    md_state_t         state_q;
    logic [2:0]        op_q;
    logic [XLEN-1:0]   hi_q, lo_q, mcand_q, dvd_q;
    logic              neg_q, rneg_q, bzero_q;
    logic [SHW:0]      cnt_q;

    logic              a_neg, b_neg, div_ge;
    logic [XLEN-1:0]   abs_a, abs_b, hi_d, lo_d, div_sub, q_n, r_n, md_res;
    logic [XLEN:0]     mul_sum, div_sh;
    logic [2*XLEN-1:0] prod_n;

    // Operands are reduced to magnitudes; signs are re-applied once at DONE.
    always_comb begin
        a_neg = fwd_a[XLEN-1] & (bus.MdOpE == 3'b001 || bus.MdOpE == 3'b010 ||
                                 bus.MdOpE == 3'b100 || bus.MdOpE == 3'b110);
        b_neg = fwd_b[XLEN-1] & (bus.MdOpE == 3'b001 || bus.MdOpE == 3'b100 ||
                                 bus.MdOpE == 3'b110);
        abs_a = a_neg ? -fwd_a : fwd_a;
        abs_b = b_neg ? -fwd_b : fwd_b;

        mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : {(XLEN+1){1'b0}});
        div_sh  = {hi_q, lo_q[XLEN-1]};
        div_ge  = (div_sh >= {1'b0, mcand_q});
        div_sub = div_sh[XLEN-1:0] - mcand_q;
        if (op_q[2]) begin
            hi_d = div_ge ? div_sub : div_sh[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], div_ge};
        end else begin
            hi_d = mul_sum[XLEN:1];
            lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
        end

        prod_n = neg_q  ? -{hi_q, lo_q} : {hi_q, lo_q};
        q_n    = neg_q  ? -lo_q : lo_q;
        r_n    = rneg_q ? -hi_q : hi_q;
        case (op_q)
            3'b000:         md_res = prod_n[XLEN-1:0];
            3'b100, 3'b101: md_res = bzero_q ? {XLEN{1'b1}} : q_n;
            3'b110, 3'b111: md_res = bzero_q ? dvd_q : r_n;
            default:        md_res = prod_n[2*XLEN-1:XLEN];
        endcase
    end

    assign stall  = rst & (((state_q == MD_IDLE) & bus.MdE) | (state_q == MD_BUSY));
    assign ex_res = (state_q == MD_DONE) ? md_res : alu_res;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= MD_IDLE;
            op_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            mcand_q <= '0;
            dvd_q   <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            bzero_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                MD_IDLE: if (bus.MdE) begin
                    op_q    <= bus.MdOpE;
                    dvd_q   <= fwd_a;
                    bzero_q <= (fwd_b == '0);
                    neg_q   <= a_neg ^ b_neg;
                    rneg_q  <= a_neg;
                    hi_q    <= '0;
                    lo_q    <= bus.MdOpE[2] ? abs_a : abs_b;
                    mcand_q <= bus.MdOpE[2] ? abs_b : abs_a;
                    cnt_q   <= '0;
                    state_q <= MD_BUSY;
                end
                MD_BUSY: begin
                    hi_q  <= hi_d;
                    lo_q  <= lo_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == (SHW+1)'(XLEN-1)) state_q <= MD_DONE;
                end
                default: state_q <= MD_IDLE;
            endcase
        end
    end
`else
    logic unused_md;
    assign unused_md = ^{bus.MdE, bus.MdOpE};
    assign stall     = 1'b0;
    assign ex_res    = alu_res;
`endif

    logic            regwrite_q, memwrite_q, memread_q;
    logic [1:0]      rsrc_q;
    logic [4:0]      rd_q;
    logic [XLEN-1:0] res_q, wd_q, pc4_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regwrite_q <= 1'b0;
            memwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            rsrc_q     <= '0;
            rd_q       <= '0;
            res_q      <= '0;
            wd_q       <= '0;
            pc4_q      <= '0;
        end else if (stall) begin
            regwrite_q <= 1'b0;
            memwrite_q <= 1'b0;
            memread_q  <= 1'b0;
        end else begin
            regwrite_q <= bus.RegWriteE;
            memwrite_q <= bus.MemWriteE;
            memread_q  <= (bus.ResultSrcE == 2'b01);
            rsrc_q     <= bus.ResultSrcE;
            rd_q       <= bus.RdE;
            res_q      <= ex_res;
            wd_q       <= fwd_b;
            pc4_q      <= bus.PCPlus4E;
        end
    end

    assign bus.RegWriteM      = regwrite_q;
    assign bus.MemWriteM      = memwrite_q;
    assign bus.MemReadM       = memread_q;
    assign bus.ResultSrcM     = rsrc_q;
    assign bus.RdM            = rd_q;
    assign bus.ALUResultM_out = res_q;
    assign bus.WriteDataM     = wd_q;
    assign bus.PCPlus4M       = pc4_q;
endmodule

// File: tb/tb_execute_cycle_param.sv
// tb/tb_execute_cycle_param.sv - vector table, random reference-model and MDU sequence bench for execute_cycle_param.
module tb_execute_cycle_param;
    logic clk;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    execute_cycle_param_if #(.XLEN(32)) bus ();
    execute_cycle_param #(.XLEN(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    typedef struct {
        logic [3:0]  op;
        logic [31:0] rd1, rd2, imm;
        logic        alusrc;
        logic [1:0]  fa, fb;
        logic [2:0]  bt;
        logic        br, jmp, jalr;
        logic [31:0] exp_res;
        logic        exp_pc;
        logic [31:0] exp_tgt;
    } vec_t;

    localparam logic [31:0] PC0  = 32'h100;
    localparam logic [31:0] RESW = 32'h55;
    localparam logic [31:0] ALUM = 32'h7;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] m_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int sh;
        sh = int'(b % 32);
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            4'd6: return (a < b) ? 32'd1 : 32'd0;
            4'd7: return 32'(longint'(a) * (longint'(1) << sh));
            4'd8: return 32'(longint'(a) / (longint'(1) << sh));
            4'd9: return 32'(longint'(int'(a)) >>> sh);
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic m_br(input logic [2:0] bt, input logic [31:0] a, input logic [31:0] b);
        case (bt)
            3'b000: return a == b;
            3'b001: return a != b;
            3'b100: return int'(a) < int'(b);
            3'b101: return int'(a) >= int'(b);
            3'b110: return a < b;
            3'b111: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] m_fwd(input logic [1:0] f, input logic [31:0] r);
        return (f == 2'b01) ? bus.ResultW : (f == 2'b10) ? bus.ALUResultM : r;
    endfunction

    function automatic logic [31:0] m_mdu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        logic [63:0] p;
        sa = longint'(int'(a));
        sb = longint'(int'(b));
        case (op)
            3'd0: begin p = 64'(sa * sb); return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * longint'({32'd0, b})); return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFFFFFF : 32'(sa / sb);
            3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
            3'd6: return (b == 0) ? a : 32'(sa % sb);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    task automatic drive_zero();
        bus.RegWriteE = 0; bus.MemWriteE = 0; bus.JumpE = 0; bus.JalrE = 0;
        bus.BranchE = 0; bus.ALUSrcE = 0; bus.BranchTypeE = 3'b010; bus.ResultSrcE = 0;
        bus.ALUControlE = 0; bus.MdE = 0; bus.MdOpE = 0; bus.RdE = 0;
        bus.RD1_E = 0; bus.RD2_E = 0; bus.ImmExtE = 0; bus.PCE = PC0; bus.PCPlus4E = PC0 + 4;
        bus.ForwardAE = 0; bus.ForwardBE = 0; bus.ResultW = RESW; bus.ALUResultM = ALUM;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        @(negedge clk);
        drive_zero();
        bus.ALUControlE = v.op; bus.RD1_E = v.rd1; bus.RD2_E = v.rd2; bus.ImmExtE = v.imm;
        bus.ALUSrcE = v.alusrc; bus.ForwardAE = v.fa; bus.ForwardBE = v.fb;
        bus.BranchTypeE = v.bt; bus.BranchE = v.br; bus.JumpE = v.jmp; bus.JalrE = v.jalr;
        bus.RdE = 5'(idx);
        #1;
        check($sformatf("vec%0d_pcsrc", idx), {31'd0, bus.PCSrcE}, {31'd0, v.exp_pc});
        check($sformatf("vec%0d_target", idx), bus.PCTargetE, v.exp_tgt);
        @(posedge clk); #1;
        check($sformatf("vec%0d_result", idx), bus.ALUResultM_out, v.exp_res);
    endtask

`ifdef EXEC_MDU_EN
    task automatic md_run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input string nm);
        int stalls, bub_err, pc_err;
        bit done;
        stalls = 0; bub_err = 0; pc_err = 0; done = 0;
        @(negedge clk);
        drive_zero();
        bus.MdE = 1; bus.MdOpE = op; bus.RD1_E = a; bus.RD2_E = b;
        bus.RegWriteE = 1; bus.RdE = 5'd9; bus.JumpE = 1;
        for (int i = 0; i < 100 && !done; i++) begin
            #1;
            if (bus.StallE) begin
                stalls++;
                if (bus.PCSrcE !== 1'b0) pc_err++;
                @(posedge clk); #1;
                if (bus.RegWriteM !== 1'b0) bub_err++;
                @(negedge clk);
            end else begin
                done = 1;
            end
        end
        check({nm, "_stall_cycles"}, 32'(stalls), 32'd33);
        check({nm, "_bubbles"}, 32'(bub_err), 32'd0);
        check({nm, "_pcsrc_gated"}, 32'(pc_err), 32'd0);
        check({nm, "_finished"}, {31'd0, done}, 32'd1);
        @(posedge clk); #1;
        check({nm, "_result"}, bus.ALUResultM_out, exp);
        check({nm, "_regwrite"}, {31'd0, bus.RegWriteM}, 32'd1);
        @(negedge clk);
        bus.MdE = 0; bus.JumpE = 0;
    endtask
`endif

    vec_t vt[18];

    initial begin
        vt[0]  = '{4'h0, 32'd5,        32'd0,   32'd3,    1'b1, 2'b10, 2'b00, 3'b010, 1'b0, 1'b0, 1'b0, 32'd10,       1'b0, 32'h103};
        vt[1]  = '{4'h1, 32'd10,       32'd3,   32'd0,    1'b0, 2'b00, 2'b00, 3'b010, 1'b0, 1'b0, 1'b0, 32'd7,        1'b0, 32'h100};
        vt[2]  = '{4'h2, 32'hF0F0,     32'hFF00, 32'd0,   1'b0, 2'b00, 2'b00, 3'b010, 1'b0, 1'b0, 1'b0, 32'hF000,     1'b0, 32'h100};
        vt[3]  = '{4'h3, 32'hF0F0,     32'h0F0F, 32'd0,   1'b0, 2'b00, 2'b00, 3'b010, 1'b0, 1'b0, 1'b0, 32'hFFFF,     1'b0, 32'h100};
        vt[4]  = '{4'h4, 32'hFF,       32'h0F,  32'd0,    1'b0, 2'b00, 2'b00, 3'b010, 1'b0, 1'b0, 1'b0, 32'hF0,       1'b0, 32'h100};
        vt[5]  = '{4'h5, 32'hFFFFFFFF, 32'd1,   32'd0,    1'b0, 2'b00, 2'b00, 3'b010, 1'b0, 1'b0, 1'b0, 32'd1,        1'b0, 32'h100};
        vt[6]  = '{4'h6, 32'hFFFFFFFF, 32'd1,   32'd0,    1'b0, 2'b00, 2'b00, 3'b010, 1'b0, 1'b0, 1'b0, 32'd0,        1'b0, 32'h100};
        vt[7]  = '{4'h7, 32'd1,        32'h3F,  32'd0,    1'b0, 2'b00, 2'b00, 3'b010, 1'b0, 1'b0, 1'b0, 32'h80000000, 1'b0, 32'h100};
        vt[8]  = '{4'h8, 32'h80000000, 32'd4,   32'd0,    1'b0, 2'b00, 2'b00, 3'b010, 1'b0, 1'b0, 1'b0, 32'h08000000, 1'b0, 32'h100};
        vt[9]  = '{4'h9, 32'h80000000, 32'd4,   32'd0,    1'b0, 2'b00, 2'b00, 3'b010, 1'b0, 1'b0, 1'b0, 32'hF8000000, 1'b0, 32'h100};
        vt[10] = '{4'hF, 32'd5,        32'd6,   32'd0,    1'b0, 2'b00, 2'b00, 3'b010, 1'b0, 1'b0, 1'b0, 32'd0,        1'b0, 32'h100};
        vt[11] = '{4'h0, 32'hFFFFFFFF, 32'd1,   32'h20,   1'b0, 2'b00, 2'b00, 3'b110, 1'b1, 1'b0, 1'b0, 32'd0,        1'b0, 32'h120};
        vt[12] = '{4'h0, 32'hFFFFFFFF, 32'd1,   32'h20,   1'b0, 2'b00, 2'b00, 3'b100, 1'b1, 1'b0, 1'b0, 32'd0,        1'b1, 32'h120};
        vt[13] = '{4'h0, 32'h1001,     32'd0,   32'd4,    1'b1, 2'b00, 2'b00, 3'b010, 1'b0, 1'b0, 1'b1, 32'h1005,     1'b1, 32'h1004};
        vt[14] = '{4'h0, 32'd1,        32'd999, 32'd0,    1'b0, 2'b11, 2'b01, 3'b010, 1'b0, 1'b0, 1'b0, 32'h56,       1'b0, 32'h100};
        vt[15] = '{4'h0, 32'h55,       32'd0,   32'd8,    1'b0, 2'b00, 2'b01, 3'b000, 1'b1, 1'b0, 1'b0, 32'hAA,       1'b1, 32'h108};
        vt[16] = '{4'h3, 32'd0,        32'd0,   32'h40,   1'b0, 2'b00, 2'b00, 3'b010, 1'b0, 1'b1, 1'b0, 32'd0,        1'b1, 32'h140};
        vt[17] = '{4'h0, 32'd0,        32'd0,   32'd0,    1'b0, 2'b00, 2'b00, 3'b011, 1'b1, 1'b0, 1'b0, 32'd0,        1'b0, 32'h100};

        rst = 1'b0;
        drive_zero();
        repeat (3) @(posedge clk);
        #1;
        check("reset_result", bus.ALUResultM_out, 32'd0);
        check("reset_rdm", {27'd0, bus.RdM}, 32'd0);
        check("reset_ctrl", {29'd0, bus.RegWriteM, bus.MemWriteM, bus.MemReadM}, 32'd0);
        check("reset_pc4", bus.PCPlus4M, 32'd0);
        check("reset_stall", {31'd0, bus.StallE}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        foreach (vt[i]) run_vec(vt[i], i);

        for (int n = 0; n < 200; n++) begin
            logic [31:0] a, b, sb, e_res, e_tgt;
            logic        e_pc;
            @(negedge clk);
            bus.ALUControlE = 4'($urandom_range(0, 15));
            bus.RD1_E = $urandom; bus.RD2_E = (n % 4 == 0) ? bus.RD1_E : $urandom;
            bus.ImmExtE = $urandom; bus.PCE = $urandom; bus.PCPlus4E = $urandom;
            bus.ResultW = $urandom; bus.ALUResultM = $urandom;
            bus.ForwardAE = 2'($urandom); bus.ForwardBE = 2'($urandom);
            bus.ALUSrcE = 1'($urandom); bus.BranchTypeE = 3'($urandom);
            bus.BranchE = 1'($urandom); bus.JumpE = ($urandom_range(0, 7) == 0);
            bus.JalrE = ($urandom_range(0, 7) == 0);
            bus.RegWriteE = 1'($urandom); bus.MemWriteE = 1'($urandom);
            bus.ResultSrcE = 2'($urandom); bus.RdE = 5'($urandom); bus.MdOpE = 3'($urandom);
`ifdef EXEC_MDU_EN
            bus.MdE = 1'b0;
`else
            bus.MdE = 1'($urandom);
`endif
            a = m_fwd(bus.ForwardAE, bus.RD1_E);
            b = m_fwd(bus.ForwardBE, bus.RD2_E);
            sb = bus.ALUSrcE ? bus.ImmExtE : b;
            e_res = m_alu(bus.ALUControlE, a, sb);
            e_pc = bus.JumpE | bus.JalrE | (bus.BranchE & m_br(bus.BranchTypeE, a, b));
            e_tgt = bus.JalrE ? ((a + bus.ImmExtE) & 32'hFFFFFFFE) : (bus.PCE + bus.ImmExtE);
            #1;
            check("rnd_stall", {31'd0, bus.StallE}, 32'd0);
            check("rnd_pcsrc", {31'd0, bus.PCSrcE}, {31'd0, e_pc});
            check("rnd_target", bus.PCTargetE, e_tgt);
            @(posedge clk); #1;
            check("rnd_result", bus.ALUResultM_out, e_res);
            check("rnd_wdata", bus.WriteDataM, b);
            check("rnd_ctrl", {bus.RdM, bus.ResultSrcM, bus.RegWriteM, bus.MemWriteM, bus.MemReadM},
                  {bus.RdE, bus.ResultSrcE, bus.RegWriteE, bus.MemWriteE, bus.ResultSrcE == 2'b01});
            check("rnd_pc4", bus.PCPlus4M, bus.PCPlus4E);
        end

`ifdef EXEC_MDU_EN
        md_run(3'd0, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFEB, "mul_neg3x7");
        md_run(3'd3, 32'h80000000, 32'h80000000, 32'h40000000, "mulhu_min");
        md_run(3'd4, 32'd7, 32'd0, 32'hFFFFFFFF, "div_by0");
        md_run(3'd6, 32'd7, 32'd0, 32'd7, "rem_by0");
        md_run(3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, "div_ovf");
        md_run(3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0, "rem_ovf");
        for (int n = 0; n < 8; n++) begin
            logic [2:0]  op;
            logic [31:0] a, b;
            op = 3'(n);
            a = $urandom;
            b = (n == 7) ? 32'd0 : ((n % 2 == 0) ? 32'($urandom_range(1, 300)) : $urandom);
            md_run(op, a, b, m_mdu(op, a, b), $sformatf("md_rnd%0d", n));
        end

        @(negedge clk);
        drive_zero();
        bus.RD1_E = 32'h1200; bus.RD2_E = 32'h34; bus.RdE = 5'd3; bus.RegWriteE = 1;
        @(posedge clk); #1;
        check("pre_rst_result", bus.ALUResultM_out, 32'h1234);
        @(negedge clk);
        bus.MdE = 1; bus.MdOpE = 3'd0; bus.RD1_E = 32'd6; bus.RD2_E = 32'd7;
        repeat (11) @(posedge clk);
        #3;
        check("busy_stall_before_rst", {31'd0, bus.StallE}, 32'd1);
        rst = 1'b0;
        #1;
        check("rst_busy_stall", {31'd0, bus.StallE}, 32'd0);
        check("rst_busy_result", bus.ALUResultM_out, 32'd0);
        check("rst_busy_rdm", {27'd0, bus.RdM}, 32'd0);
        @(negedge clk);
        bus.MdE = 0;
        @(negedge clk);
        rst = 1'b1;
        md_run(3'd0, 32'd6, 32'd7, 32'd42, "mul_after_rst");
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/execute_cycle_param.md
EXECUTE_CYCLE_PARAM -- requirements
Module: execute_cycle_param

Interface
REQ-001 Parameter XLEN, default 32: datapath width for operands, ALU, MDU, PC and pipeline registers.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 RegWriteE, MemWriteE, JumpE, JalrE, BranchE, ALUSrcE  input  1 each  ID/EX control bits.
REQ-005 BranchTypeE  input  3  funct3 branch condition.
REQ-006 ResultSrcE  input  2  writeback select; 2'b01 = load.
REQ-007 ALUControlE  input  4  ALU operation.
REQ-008 MdE  input  1  instruction in EX is a multiply/divide op; MdOpE  input  3  M-extension funct3.
REQ-009 RdE  input  5  destination register.
REQ-010 RD1_E, RD2_E, ImmExtE, PCE, PCPlus4E  input  XLEN each  operands, immediate, PC values.
REQ-011 ForwardAE, ForwardBE  input  2  00 register, 01 ResultW, 10 ALUResultM, 11 register.
REQ-012 ResultW, ALUResultM  input  XLEN  forwarding sources.
REQ-013 RegWriteM, MemWriteM, MemReadM  output  1  registered EX/MEM controls.
REQ-014 ResultSrcM 2, RdM 5, ALUResultM_out XLEN, WriteDataM XLEN, PCPlus4M XLEN  output  registered EX/MEM data.
REQ-015 PCSrcE  output  1  redirect fetch; PCTargetE  output  XLEN  redirect target (both combinational).
REQ-016 StallE  output  1  combinational; high = hazard unit holds IF/ID/ID-EX.

Function
REQ-017 SrcA = forwarded RD1; SrcB = ALUSrcE ? ImmExtE : forwarded RD2; WriteDataM = forwarded RD2.
REQ-018 ALUControlE: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt, 0110 sltu, 0111 sll, 1000 srl, 1001 sra; shift amount = SrcB[log2(XLEN)-1:0]; other codes give 0.
REQ-019 BranchTypeE: 000 eq, 001 ne, 100 lt, 101 ge, 110 ltu, 111 geu on SrcA vs forwarded RD2; other codes never taken.
REQ-020 PCSrcE = JumpE | JalrE | (BranchE & cond); PCTargetE = JalrE ? (SrcA+ImmExtE)&~1 : PCE+ImmExtE; PCSrcE forced 0 while StallE=1.
REQ-021 MDU FSM IDLE/BUSY/DONE: IDLE and MdE=1 -> latch forwarded operands and MdOpE, StallE=1, go BUSY; BUSY runs XLEN cycles one iteration each, StallE=1; then DONE, StallE=0, EX/MEM captures MDU result, return IDLE.
REQ-022 MDU op latency fixed: StallE high XLEN+1 cycles, result in ALUResultM_out at end of cycle XLEN+2; independent of operand values.
REQ-023 MdOpE: 000 MUL low, 001 MULH ss, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU (iterative shift-add / restoring divide).
REQ-024 Divide by zero: quotient all ones, remainder = dividend; signed overflow (min / -1): quotient = min, remainder 0.
REQ-025 Every cycle with StallE=1, EX/MEM loads a bubble: RegWriteM, MemWriteM, MemReadM = 0, other M fields hold.
REQ-026 Non-stalled cycles: EX/MEM loads E controls, RdE, ALU (or MDU in DONE) result, PCPlus4E; MemReadM = (ResultSrcE==2'b01).
REQ-027 MdE ignored in BUSY/DONE; MdE held high after DONE starts a new operation only if a new instruction arrives (hazard unit releases stall in DONE).

Reset
REQ-028 rst low, any state including BUSY: FSM -> IDLE, StallE=0 immediately, all EX/MEM outputs and MDU registers 0; operation discarded.
REQ-029 First MdE after rst deassertion starts a full-length operation.

Configuration
REQ-030 Macro EXEC_MDU_EN: defined -> MDU, FSM and StallE logic present per REQ-021..027; undefined -> no MDU, StallE tied 0, MdE/MdOpE ignored, instruction executes per ALUControlE in one cycle.

Verification (XLEN=32)
REQ-031 RD1_E=5, ForwardAE=10, ALUResultM=7, ALUSrcE=1, ImmExtE=3, add -> ALUResultM_out=10 after one edge.
REQ-032 RD1=0xFFFFFFFF, RD2=1: BranchTypeE=110 -> PCSrcE=0; 100 -> PCSrcE=1, PCTargetE=PCE+ImmExtE.
REQ-033 JalrE=1, RD1=0x1001, ImmExtE=4 -> PCSrcE=1, PCTargetE=0x1004.
REQ-034 MUL -3*7 -> StallE high 33 cycles, M bubbles, ALUResultM_out=0xFFFFFFEB; MULHU 0x80000000*0x80000000 -> 0x40000000.
REQ-035 DIV 7/0 -> 0xFFFFFFFF; REM 7/0 -> 7; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same -> 0.
REQ-036 rst low in BUSY cycle 10 -> StallE=0 and outputs 0 asynchronously; subsequent MUL 6*7 -> 42 with full latency.
